// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of one shared combinational ALU: grant, issue, wait, capture, respond.
// Optional macro ALU_ARB_ROUND_ROBIN_EN selects round-robin ties; the default build uses fixed priority (port 0).
module alu_arbiter #(
    parameter int OP_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_instr,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_instr,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,

    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_result,
    output logic [2:0]  rsp0_flags,

    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_result,
    output logic [2:0]  rsp1_flags,

    output logic [31:0] alu_instruction,
    output logic [31:0] alu_regA,
    output logic [31:0] alu_regB,
    input  logic [31:0] alu_result,
    input  logic [2:0]  alu_flags,

    output logic        busy
);

    localparam int              CW       = (OP_LATENCY > 1) ? $clog2(OP_LATENCY) : 1;
    localparam logic [CW-1:0]   CNT_LOAD = CW'(OP_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic          owner;
    logic          grant;
    logic          tie_pick;
    logic          accept;
    logic          rsp_done;
    logic          cnt_zero;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    // Port served most recently; a tie goes to the other one.
    logic last;
    assign tie_pick = ~last;
`else
    assign tie_pick = 1'b0;
`endif

    assign grant    = req1_valid & (~req0_valid | tie_pick);
    assign cnt_zero = (cnt == '0);
    assign busy     = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        rsp_done   = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = req0_valid & ~grant;
                req1_ready = grant;
                accept     = grant ? req1_valid : req0_valid;
                if (accept) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (cnt_zero) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_done = owner ? (rsp1_valid & rsp1_ready) : (rsp0_valid & rsp0_ready);
                if (rsp_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operands only move on accept, so the ALU inputs stay quiet between operations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt             <= '0;
            owner           <= 1'b0;
            alu_instruction <= '0;
            alu_regA        <= '0;
            alu_regB        <= '0;
            rsp0_valid      <= 1'b0;
            rsp0_result     <= '0;
            rsp0_flags      <= '0;
            rsp1_valid      <= 1'b0;
            rsp1_result     <= '0;
            rsp1_flags      <= '0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            last            <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner           <= grant;
                        cnt             <= CNT_LOAD;
                        alu_instruction <= grant ? req1_instr : req0_instr;
                        alu_regA        <= grant ? req1_a     : req0_a;
                        alu_regB        <= grant ? req1_b     : req0_b;
                    end
                end
                EXEC: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - 1'b1;
                    end else if (owner) begin
                        rsp1_valid  <= 1'b1;
                        rsp1_result <= alu_result;
                        rsp1_flags  <= alu_flags;
                    end else begin
                        rsp0_valid  <= 1'b1;
                        rsp0_result <= alu_result;
                        rsp0_flags  <= alu_flags;
                    end
                end
                RESP: begin
                    if (rsp_done) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
                        last       <= owner;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    a_one_ready: assert property (@(posedge clk) disable iff (!rst_n)
        !(req0_ready && req1_ready));

    a_one_rsp: assert property (@(posedge clk) disable iff (!rst_n)
        !(rsp0_valid && rsp1_valid));

endmodule
